// File: rtl/serial_display_driver_if.sv
// serial_display_driver_if
//   Request/status and three-wire serial bundle for serial_display_driver.
//   master : frame source (drives i_en/i_start/i_digits, observes status and serial lines)
//   slave  : the driver itself
//   Signals:
//     i_en            block enable
//     i_start         frame request
//     i_digits        NUM_DIGITS*8 lane data, lane d at [8d+7:8d]
//     o_busy          frame in progress
//     o_done          one-cycle pulse at frame end
//     o_serial_data   shift data
//     o_serial_clk    shift clock
//     o_serial_latch  storage-register latch
interface serial_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic                    i_en;
    logic                    i_start;
    logic [NUM_DIGITS*8-1:0] i_digits;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_serial_data;
    logic                    o_serial_clk;
    logic                    o_serial_latch;

    modport master (
        output i_en, i_start, i_digits,
        input  o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch
    );

    modport slave (
        input  i_en, i_start, i_digits,
        output o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch
    );
endinterface

// File: rtl/serial_display_driver.sv
// serial_display_driver
//   Serialises NUM_DIGITS 8-bit lanes onto a chain of 74HC595-style shift
//   registers. Lane NUM_DIGITS-1 goes out first so lane 0 ends nearest the
//   driver; bit order within a lane follows MSB_FIRST. Each bit period is
//   2*DIV i_clk cycles (serial_clk low half then high half), followed by a
//   2*DIV cycle latch pulse and a one-cycle done state. One request arriving
//   while busy is remembered and started from DONE.
//   Ports:
//     i_clk      system clock
//     i_reset_n  asynchronous active-low reset
//     bus        serial_display_driver_if.slave (enable/start/digits in,
//                busy/done/serial data/clk/latch out)
//   Build option:
//     DIGIT_DECODE_EN  when defined, each lane is hex-to-7-segment decoded
//                      (bit 7 passed through as dp) before shifting.
module serial_display_driver #(
    parameter int unsigned SYS_CLK_HZ   = 5_000_000,
    parameter int unsigned SHIFT_CLK_HZ = 1_000_000,
    parameter int unsigned NUM_DIGITS   = 6,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    serial_display_driver_if.slave bus
);

    localparam int unsigned DIV_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned PERIOD  = 2 * DIV;
    localparam int unsigned W       = NUM_DIGITS * 8;
    localparam int unsigned DCW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned BCW     = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     frame;
    logic [W-1:0]     frame_load;
    logic [DCW-1:0]   div_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic             pending;
    logic             start_frame;
    logic             period_end;
    logic             last_bit;

    function automatic logic [7:0] lane_map(input logic [7:0] raw);
`ifdef DIGIT_DECODE_EN
        logic [6:0] seg;
        case (raw[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return {raw[7], seg};
`else
        return raw;
`endif
    endfunction

    // Frame register is laid out in transmit order: frame[W-1] is the next
    // bit on the wire, so shifting left walks lanes from NUM_DIGITS-1 down.
    always_comb begin
        logic [7:0] lane;
        frame_load = '0;
        lane       = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            lane = lane_map(bus.i_digits[8*d +: 8]);
            for (int unsigned b = 0; b < 8; b++) begin
                frame_load[8*d + b] = MSB_FIRST ? lane[b] : lane[7-b];
            end
        end
    end

    assign period_end = (div_cnt == DCW'(PERIOD - 1));
    assign last_bit   = (bit_cnt == BCW'(W - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        start_frame        = 1'b0;
        bus.o_busy         = 1'b0;
        bus.o_done         = 1'b0;
        bus.o_serial_data  = 1'b0;
        bus.o_serial_clk   = 1'b0;
        bus.o_serial_latch = 1'b0;
        case (state)
            IDLE: begin
                // A request held over from a frame that ended while disabled
                // starts as soon as the block is enabled again.
                if (bus.i_en && (bus.i_start || pending)) begin
                    start_frame = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                bus.o_busy        = 1'b1;
                bus.o_serial_data = frame[W-1];
                bus.o_serial_clk  = (div_cnt >= DCW'(DIV));
                if (period_end && last_bit) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                bus.o_busy         = 1'b1;
                bus.o_serial_latch = 1'b1;
                if (period_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.o_busy = 1'b1;
                bus.o_done = 1'b1;
                if (bus.i_en && pending) begin
                    start_frame = 1'b1;
                    state_next  = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start_frame) begin
            frame   <= frame_load;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            if (period_end) begin
                div_cnt <= '0;
                frame   <= {frame[W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (state == LATCH) begin
            div_cnt <= period_end ? '0 : div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
        end
    end

    // One-deep request buffer: any number of starts while busy collapse
    // into one; it is consumed only when a frame actually starts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending <= 1'b0;
        end else if (start_frame) begin
            pending <= 1'b0;
        end else if (bus.i_en && bus.i_start && state != IDLE) begin
            pending <= 1'b1;
        end
    end

endmodule
